// File: rtl/ram_addr_scanner.sv
// RAM read-address generator for the lab 2 demo: timed auto-scan,
// push-button single-step and direct load from switches.
module ram_addr_scanner #(
  parameter int ADDR_W      = 5,
  parameter int TICK_CYCLES = 50000000,
  parameter int CNT_W       = 26
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              run,
  input  logic              step_key,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_changed,
  output logic              scanning
);

  typedef enum logic {
    PAUSE = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] TICK_LAST =
    CNT_W'(TICK_CYCLES - 1);

  state_t            state_q;
  state_t            state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;
  logic              chg_q;
  logic              chg_d;
  logic [2:0]        key_q;
  logic [2:0]        key_d;
  logic              step_pulse;
  logic              tick;
  logic              adv;

  // key_q[0], key_q[1]: synchronizer; key_q[2]: previous synced level
  assign step_pulse = key_q[2] & ~key_q[1];

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    addr_d  = addr_q;
    chg_d   = 1'b0;
    tick    = 1'b0;
    key_d   = {key_q[1:0], step_key};
    unique case (state_q)
      PAUSE: begin
        if (run) state_d = RUN;
      end
      RUN: begin
        tick  = (cnt_q == TICK_LAST);
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        if (!run) begin
          state_d = PAUSE;
          cnt_d   = '0;
        end
      end
      default: state_d = PAUSE;
    endcase
    adv = (state_q == RUN) ? tick : step_pulse;
    // load wins; a coincident step or tick is dropped
    if (load) begin
      addr_d = load_addr;
      cnt_d  = '0;
      chg_d  = 1'b1;
    end else if (adv) begin
      addr_d = addr_q + 1'b1;
      chg_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= PAUSE;
      cnt_q   <= '0;
      addr_q  <= '0;
      chg_q   <= 1'b0;
      key_q   <= 3'b111;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      chg_q   <= chg_d;
      key_q   <= key_d;
    end
  end

  assign addr         = addr_q;
  assign addr_changed = chg_q;
  assign scanning     = (state_q == RUN);

endmodule

// File: tb/tb_ram_addr_scanner.sv
// Scoreboard bench for ram_addr_scanner: a cycle-indexed model
// predicts address updates, a monitor matches them against the DUT.
module tb_ram_addr_scanner;

  localparam int AW   = 5;
  localparam int TICK = 4;
  localparam int CW   = 3;

  logic          clk      = 1'b0;
  logic          reset_n  = 1'b0;
  logic          run      = 1'b0;
  logic          step_key = 1'b1;
  logic          load     = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [AW-1:0] addr;
  logic          addr_changed;
  logic          scanning;

  int n_tests = 0;
  int n_fail  = 0;

  ram_addr_scanner #(
    .ADDR_W(AW),
    .TICK_CYCLES(TICK),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .run(run),
    .step_key(step_key),
    .load(load),
    .load_addr(load_addr),
    .addr(addr),
    .addr_changed(addr_changed),
    .scanning(scanning)
  );

  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d",
               name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int unsigned cyc;
    int          a;
  } upd_t;

  upd_t        exp_q[$];
  upd_t        u;
  int unsigned edge_n = 0;
  int unsigned m_ref  = 0;
  int          m_addr = 0;
  bit          m_run  = 1'b0;
  bit          kh[$];
  bit          fell;
  bit          tick_due;
  bit          adv;
  bit          due;

  initial begin
    kh = '{1'b1, 1'b1, 1'b1};
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_addr = 0;
        m_run  = 1'b0;
        kh     = '{1'b1, 1'b1, 1'b1};
      end else begin
        edge_n++;
        // key seen released 3 edges ago and pressed 2 edges ago
        fell     = kh[0] && !kh[1];
        tick_due = m_run && (edge_n - m_ref == TICK);
        adv      = m_run ? tick_due : fell;
        if (load) begin
          m_addr = int'(load_addr);
          m_ref  = edge_n;
          exp_q.push_back('{edge_n, m_addr});
        end else if (adv) begin
          m_addr = (m_addr + 1) % 32;
          if (tick_due) m_ref = edge_n;
          exp_q.push_back('{edge_n, m_addr});
        end
        if (!m_run && run) m_ref = edge_n;
        m_run = run;
        kh.push_back(step_key);
        void'(kh.pop_front());
      end
    end
  end

  // ---------------- monitor ----------------
  initial forever begin
    @(negedge clk);
    if (reset_n) begin
      check("addr", 32'(addr), 32'(m_addr));
      check("scanning", 32'(scanning), 32'(m_run));
      due = exp_q.size() > 0 && exp_q[0].cyc <= edge_n;
      check("pulse", 32'(addr_changed), 32'(due));
      if (addr_changed && exp_q.size() > 0) begin
        u = exp_q.pop_front();
        check("upd_addr", 32'(addr), 32'(u.a));
      end else if (due) begin
        void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    run     = 1'b0;
    load    = 1'b0;
    step_key = 1'b1;
    tick_n(3);
    reset_n = 1'b1;
  endtask

  initial begin
    // reset and idle
    tick_n(2);
    check("rst_addr", 32'(addr), 0);
    check("rst_chg", 32'(addr_changed), 0);
    check("rst_scan", 32'(scanning), 0);
    do_reset();
    tick_n(20);
    check("idle_addr", 32'(addr), 0);

    // auto-scan and wrap
    run = 1'b1;
    tick_n(1);
    check("scan_on", 32'(scanning), 1);
    tick_n(4);
    check("first_adv", 32'(addr), 1);
    check("first_chg", 32'(addr_changed), 1);
    tick_n(124);
    check("wrap_addr", 32'(addr), 0);
    check("wrap_chg", 32'(addr_changed), 1);
    tick_n(8);

    // asynchronous reset in mid-cycle
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("async_addr", 32'(addr), 0);
    check("async_scan", 32'(scanning), 0);
    check("async_chg", 32'(addr_changed), 0);
    run = 1'b0;
    tick_n(1);
    reset_n = 1'b1;

    // single step held long, then a second press
    tick_n(10);
    step_key = 1'b0;
    tick_n(2);
    check("step_early", 32'(addr), 0);
    tick_n(1);
    check("step_addr", 32'(addr), 1);
    check("step_chg", 32'(addr_changed), 1);
    tick_n(17);
    check("step_hold", 32'(addr), 1);
    step_key = 1'b1;
    tick_n(5);
    step_key = 1'b0;
    tick_n(5);
    check("step2", 32'(addr), 2);
    step_key = 1'b1;
    tick_n(5);

    // key presses while scanning
    run = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 0) step_key = ~step_key;
      tick_n(1);
    end
    step_key = 1'b1;
    run = 1'b0;
    tick_n(5);

    // load colliding with a due tick
    do_reset();
    run = 1'b1;
    tick_n(4);
    load = 1'b1;
    load_addr = 5'd17;
    tick_n(1);
    load = 1'b0;
    check("load_win", 32'(addr), 17);
    check("load_chg", 32'(addr_changed), 1);
    tick_n(3);
    check("load_hold", 32'(addr), 17);
    tick_n(1);
    check("post_load", 32'(addr), 18);

    // step wrap at 31, then reload of the same value
    run = 1'b0;
    load = 1'b1;
    load_addr = 5'd31;
    tick_n(1);
    load = 1'b0;
    check("load31", 32'(addr), 31);
    tick_n(3);
    step_key = 1'b0;
    tick_n(3);
    check("step_wrap", 32'(addr), 0);
    check("step_wrap_chg", 32'(addr_changed), 1);
    step_key = 1'b1;
    tick_n(3);
    load = 1'b1;
    load_addr = 5'd0;
    tick_n(1);
    load = 1'b0;
    check("reload_addr", 32'(addr), 0);
    check("reload_chg", 32'(addr_changed), 1);
    tick_n(3);

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 23) == 0) run = ~run;
      if ($urandom_range(0, 3) == 0) step_key = ~step_key;
      load = ($urandom_range(0, 15) == 0);
      load_addr = AW'($urandom_range(0, 31));
      tick_n(1);
    end
    load = 1'b0;
    run = 1'b0;
    step_key = 1'b1;
    tick_n(6);
    check("drain", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
